// File: rtl/decoder_pkg.sv
// Shared definitions for the registered one-hot decoders: mode encoding,
// state type and the one-hot helper, sized for the widest supported address.
package decoder_pkg;

   localparam int MAX_ADDR_WIDTH = 6;
   localparam int MAX_OUT_WIDTH  = 1 << MAX_ADDR_WIDTH;

   localparam logic [1:0] MODE_OFF    = 2'b00;
   localparam logic [1:0] MODE_DIRECT = 2'b01;
   localparam logic [1:0] MODE_SCAN   = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;

   // State values deliberately equal the mode encoding so st can load mode directly.
   typedef enum logic [1:0] {
      ST_OFF    = 2'b00,
      ST_DIRECT = 2'b01,
      ST_SCAN   = 2'b10,
      ST_HOLD   = 2'b11
   } state_t;

   // Callers truncate the result to their own OUT_WIDTH.
   function automatic logic [MAX_OUT_WIDTH-1:0] onehot(input logic [MAX_ADDR_WIDTH-1:0] idx);
      logic [MAX_OUT_WIDTH-1:0] res;
      res = '0;
      res[idx] = 1'b1;
      return res;
   endfunction

endpackage

// File: rtl/dwell_counter.sv
// Modulo-DWELL counter; tc is high while the count sits on its last value,
// so the owner advances on the same edge the counter rolls back to zero.
module dwell_counter #(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tc
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;

   assign tc = (count_reg == LAST);

   always_comb begin
      count_next = count_reg;
      if (clr) begin
         count_next = '0;
      end else if (en) begin
         count_next = tc ? '0 : count_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with OFF, DIRECT, self-sequencing SCAN
// and HOLD modes; every output comes straight from a flop.
module scan_decoder
   import decoder_pkg::*;
#(
   parameter int ADDR_WIDTH = 2,
   parameter int SCAN_DWELL = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [1:0]                    mode,
   input  logic [ADDR_WIDTH-1:0]         address,
   output logic [(1 << ADDR_WIDTH)-1:0]  out,
   output logic [ADDR_WIDTH-1:0]         index,
   output logic                          wrap
);

   localparam int OUT_WIDTH = 1 << ADDR_WIDTH;

   state_t                  st_reg;
   logic [ADDR_WIDTH-1:0]   index_reg;
   logic [ADDR_WIDTH-1:0]   index_next;
   logic [OUT_WIDTH-1:0]    out_reg;
   logic [OUT_WIDTH-1:0]    out_next;
   logic                    wrap_reg;
   logic                    wrap_next;

   logic                    scan_active;
   logic                    scan_entry;
   logic                    scan_run;
   logic                    dwell_tc;

   // A disabled cycle never counts as entry or as a dwell tick, so scans resume in place.
   assign scan_active = enable && (mode == MODE_SCAN);
   assign scan_entry  = scan_active && (st_reg != ST_SCAN);
   assign scan_run    = scan_active && (st_reg == ST_SCAN);

   dwell_counter #(
      .DWELL (SCAN_DWELL)
   ) u_dwell (
      .clk   (clk),
      .reset (reset),
      .en    (scan_run),
      .clr   (scan_entry),
      .tc    (dwell_tc)
   );

   always_comb begin
      index_next = index_reg;
      out_next   = '0;
      wrap_next  = 1'b0;
      if (enable) begin
         case (mode)
            MODE_DIRECT: begin
               index_next = address;
               out_next   = OUT_WIDTH'(onehot(MAX_ADDR_WIDTH'(address)));
            end
            MODE_SCAN: begin
               if (scan_entry) begin
                  index_next = address;
               end else if (dwell_tc) begin
                  index_next = index_reg + 1'b1;
                  wrap_next  = &index_reg;
               end
               out_next = OUT_WIDTH'(onehot(MAX_ADDR_WIDTH'(index_next)));
            end
            MODE_HOLD: begin
               out_next = out_reg;
            end
            default: begin
               out_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_reg    <= ST_OFF;
         index_reg <= '0;
         out_reg   <= '0;
         wrap_reg  <= 1'b0;
      end else begin
         st_reg    <= state_t'(mode);
         index_reg <= index_next;
         out_reg   <= out_next;
         wrap_reg  <= wrap_next;
      end
   end

   assign out   = out_reg;
   assign index = index_reg;
   assign wrap  = wrap_reg;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder (ADDR_WIDTH=2, SCAN_DWELL=2): directed scenarios with
// literal expectations, then randomised traffic against a behavioural model.
module tb_scan_decoder;

   localparam int AW = 2;
   localparam int DW = 2;
   localparam int OW = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [1:0]    mode;
   logic [AW-1:0] address;
   logic [OW-1:0] out;
   logic [AW-1:0] index;
   logic          wrap;

   int tests = 0;
   int fails = 0;

   scan_decoder #(
      .ADDR_WIDTH (AW),
      .SCAN_DWELL (DW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .mode    (mode),
      .address (address),
      .out     (out),
      .index   (index),
      .wrap    (wrap)
   );

   always #5 clk = ~clk;

   // Behavioural model: mode history, scan position and dwell as plain integers.
   int m_st = 0;
   int m_index = 0;
   int m_dwell = 0;
   int m_out = 0;
   int m_wrap = 0;
   bit m_valid = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_st = 0; m_index = 0; m_dwell = 0; m_out = 0; m_wrap = 0;
      end else begin
         m_wrap = 0;
         if (!enable) begin
            m_out = 0;
         end else begin
            case (int'(mode))
               0: m_out = 0;
               1: begin
                  m_index = int'(address);
                  m_out = 1 << m_index;
               end
               2: begin
                  if (m_st != 2) begin
                     m_index = int'(address);
                     m_dwell = 0;
                  end else begin
                     m_dwell = m_dwell + 1;
                     if (m_dwell == DW) begin
                        m_dwell = 0;
                        m_wrap = (m_index == OW - 1) ? 1 : 0;
                        m_index = (m_index + 1) % OW;
                     end
                  end
                  m_out = 1 << m_index;
               end
               default: ;
            endcase
         end
         m_st = int'(mode);
      end
      m_valid = 1'b1;
   end

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, plus structural invariants.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_out", int'(out), m_out);
         chk("model_index", int'(index), m_index);
         chk("model_wrap", int'(wrap), m_wrap);
         chk("onehot_or_zero", ($countones(out) <= 1) ? 1 : 0, 1);
         if (out != '0) chk("out_matches_index", int'(out), 1 << int'(index));
         if (wrap) chk("wrap_only_in_scan", m_st, 2);
      end
   end

   task automatic drive(input logic r, input logic e, input logic [1:0] m, input int a);
      reset = r; enable = e; mode = m; address = AW'(a);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string name, input int exp_out, input int exp_wrap);
      chk({name, "_out"}, int'(out), exp_out);
      chk({name, "_wrap"}, int'(wrap), exp_wrap);
      $display("[TB] %s: out=%b index=%0d wrap=%0b", name, out, index, wrap);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; mode = 2'b10; address = '0;

      // Reset while SCAN is requested
      drive(1, 1, 2'b10, 0);
      expect_state("reset", 'b0000, 0);
      chk("reset_index", int'(index), 0);

      // SCAN from address 3: 8-cycle period, wrap with the return to bit 0
      drive(0, 1, 2'b10, 3); expect_state("scan3_a", 'b1000, 0);
      drive(0, 1, 2'b10, 3); expect_state("scan3_b", 'b1000, 0);
      drive(0, 1, 2'b10, 3); expect_state("scan3_wrap", 'b0001, 1);
      drive(0, 1, 2'b10, 3); expect_state("scan3_c", 'b0001, 0);
      drive(0, 1, 2'b10, 3); expect_state("scan3_d", 'b0010, 0);
      drive(0, 1, 2'b10, 3); expect_state("scan3_e", 'b0010, 0);
      drive(0, 1, 2'b10, 3); expect_state("scan3_f", 'b0100, 0);
      chk("scan3_index", int'(index), 2);

      // Reset mid-scan at index 2
      drive(1, 1, 2'b10, 0); expect_state("reset_mid", 'b0000, 0);

      // DIRECT sweep, one address per cycle
      for (int a = 0; a < OW; a++) begin
         drive(0, 1, 2'b01, a);
         expect_state($sformatf("direct_%0d", a), 1 << a, 0);
      end

      // HOLD mid-scan at index 1, then reload on return to SCAN
      drive(0, 1, 2'b10, 1); expect_state("hold_entry", 'b0010, 0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 2'b11, 3);
         expect_state($sformatf("hold_%0d", i), 'b0010, 0);
      end
      drive(0, 1, 2'b10, 2); expect_state("hold_reload", 'b0100, 0);

      // Enable drop during SCAN; resume at the frozen position
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 2'b10, 0);
         expect_state($sformatf("disabled_%0d", i), 'b0000, 0);
      end
      drive(0, 1, 2'b10, 0); expect_state("resume_a", 'b0100, 0);
      drive(0, 1, 2'b10, 0); expect_state("resume_b", 'b1000, 0);

      // Randomised traffic, model-checked every cycle
      for (int i = 0; i < 10000; i++) begin
         logic r, e;
         logic [1:0] m;
         r = ($urandom_range(0, 127) == 0);
         e = ($urandom_range(0, 7) != 0);
         m = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
         if ($urandom_range(0, 15) == 0) m = 2'($urandom_range(0, 3));
         reset = r; enable = e; mode = m; address = AW'($urandom_range(0, OW - 1));
         @(posedge clk);
         #1;
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
